// File: rtl/lpm_lookup_pipe.sv
`default_nettype none
// ============================================================================
// Module   : lpm_lookup_pipe
// Purpose  : Pipelined longest-prefix-match route table, 3-edge latency.
// Revision : 1.0 - initial release
// ============================================================================
module lpm_lookup_pipe #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8,
   parameter int IDXW  = 3,
   parameter int IFW   = 4,
   localparam int LENW = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_key,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             res_hit,
   output logic [WIDTH-1:0] res_prefix,
   output logic [LENW-1:0]  res_len,
   output logic [IFW-1:0]   res_if,
   output logic [IDXW-1:0]  res_idx,
   input  logic             wr_en,
   input  logic [IDXW-1:0]  wr_index,
   input  logic [WIDTH-1:0] wr_prefix,
   input  logic [WIDTH-1:0] wr_mask,
   input  logic [IFW-1:0]   wr_if,
   input  logic             wr_valid,
   input  logic             flush,
   output logic             wr_err
);

   function automatic logic [LENW-1:0] popcnt(input logic [WIDTH-1:0] v);
      logic [LENW-1:0] c;
      c = '0;
      for (int b = 0; b < WIDTH; b++) c = c + LENW'(v[b]);
      return c;
   endfunction

   function automatic logic [WIDTH-1:0] len_to_mask(input logic [LENW-1:0] l);
      logic [WIDTH-1:0] m;
      for (int b = 0; b < WIDTH; b++) m[b] = (int'(l) + b) >= WIDTH;
      return m;
   endfunction

   logic [DEPTH-1:0]            valid_q,  valid_d;
   logic [DEPTH-1:0][WIDTH-1:0] prefix_q, prefix_d;
   logic [DEPTH-1:0][WIDTH-1:0] mask_q,   mask_d;
   logic [DEPTH-1:0][IFW-1:0]   if_q,     if_d;
   logic                        wr_err_q, wr_err_d;

   logic                        s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0]            s1_key_q,   s1_key_d;
   logic [DEPTH-1:0]            s1_match_q, s1_match_d;
   logic [DEPTH-1:0][LENW-1:0]  s1_len_q,   s1_len_d;
   logic [DEPTH-1:0][IFW-1:0]   s1_if_q,    s1_if_d;

   logic                        s2_valid_q, s2_valid_d;
   logic                        s2_hit_q,   s2_hit_d;
   logic [WIDTH-1:0]            s2_key_q,   s2_key_d;
   logic [LENW-1:0]             s2_len_q,   s2_len_d;
   logic [IFW-1:0]              s2_if_q,    s2_if_d;
   logic [IDXW-1:0]             s2_idx_q,   s2_idx_d;

   logic                        res_valid_q,  res_valid_d;
   logic                        res_hit_q,    res_hit_d;
   logic [WIDTH-1:0]            res_prefix_q, res_prefix_d;
   logic [LENW-1:0]             res_len_q,    res_len_d;
   logic [IFW-1:0]              res_if_q,     res_if_d;
   logic [IDXW-1:0]             res_idx_q,    res_idx_d;

   logic                        stall;
   logic                        accept;
   logic [WIDTH-1:0]            wr_inv;
   logic                        wr_ok;

   always_comb begin
      stall     = res_valid_q && !res_ready;
      req_ready = !stall;
      accept    = req_valid && !stall;

      // A mask 1..10..0 inverts to 0..01..1, which has no carry overlap with itself + 1.
      wr_inv = ~wr_mask;
      wr_ok  = wr_en && ((wr_inv & (wr_inv + WIDTH'(1))) == '0)
               && (32'(wr_index) < DEPTH);
      wr_err_d = wr_en && !wr_ok;

      valid_d  = flush ? '0 : valid_q;
      prefix_d = prefix_q;
      mask_d   = mask_q;
      if_d     = if_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (wr_ok && (wr_index == IDXW'(i))) begin
            valid_d[i]  = wr_valid;
            prefix_d[i] = wr_prefix & wr_mask;
            mask_d[i]   = wr_mask;
            if_d[i]     = wr_if;
         end
      end

      s1_valid_d = s1_valid_q;
      s1_key_d   = s1_key_q;
      s1_match_d = s1_match_q;
      s1_len_d   = s1_len_q;
      s1_if_d    = s1_if_q;
      s2_valid_d = s2_valid_q;
      s2_hit_d   = s2_hit_q;
      s2_key_d   = s2_key_q;
      s2_len_d   = s2_len_q;
      s2_if_d    = s2_if_q;
      s2_idx_d   = s2_idx_q;
      res_valid_d  = res_valid_q;
      res_hit_d    = res_hit_q;
      res_prefix_d = res_prefix_q;
      res_len_d    = res_len_q;
      res_if_d     = res_if_q;
      res_idx_d    = res_idx_q;

      if (!stall) begin
         // Interface indices are captured here so later writes cannot leak in.
         s1_valid_d = accept;
         s1_key_d   = req_key;
         for (int i = 0; i < DEPTH; i++) begin
            s1_match_d[i] = valid_q[i] && ((req_key & mask_q[i]) == prefix_q[i]);
            s1_len_d[i]   = popcnt(mask_q[i]);
            s1_if_d[i]    = if_q[i];
         end

         // Ascending scan with >= lets the highest index win on equal length.
         s2_valid_d = s1_valid_q;
         s2_key_d   = s1_key_q;
         s2_hit_d   = 1'b0;
         s2_len_d   = '0;
         s2_if_d    = '0;
         s2_idx_d   = '0;
         for (int i = 0; i < DEPTH; i++) begin
            if (s1_match_q[i] && (!s2_hit_d || (s1_len_q[i] >= s2_len_d))) begin
               s2_hit_d = 1'b1;
               s2_len_d = s1_len_q[i];
               s2_if_d  = s1_if_q[i];
               s2_idx_d = IDXW'(i);
            end
         end

         // Stored prefixes are normalised, so key & winning mask reproduces them.
         res_valid_d  = s2_valid_q;
         res_hit_d    = s2_hit_q;
         res_prefix_d = s2_key_q & len_to_mask(s2_len_q);
         res_len_d    = s2_len_q;
         res_if_d     = s2_if_q;
         res_idx_d    = s2_idx_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q      <= '0;
         prefix_q     <= '0;
         mask_q       <= '0;
         if_q         <= '0;
         wr_err_q     <= 1'b0;
         s1_valid_q   <= 1'b0;
         s1_key_q     <= '0;
         s1_match_q   <= '0;
         s1_len_q     <= '0;
         s1_if_q      <= '0;
         s2_valid_q   <= 1'b0;
         s2_hit_q     <= 1'b0;
         s2_key_q     <= '0;
         s2_len_q     <= '0;
         s2_if_q      <= '0;
         s2_idx_q     <= '0;
         res_valid_q  <= 1'b0;
         res_hit_q    <= 1'b0;
         res_prefix_q <= '0;
         res_len_q    <= '0;
         res_if_q     <= '0;
         res_idx_q    <= '0;
      end else begin
         valid_q      <= valid_d;
         prefix_q     <= prefix_d;
         mask_q       <= mask_d;
         if_q         <= if_d;
         wr_err_q     <= wr_err_d;
         s1_valid_q   <= s1_valid_d;
         s1_key_q     <= s1_key_d;
         s1_match_q   <= s1_match_d;
         s1_len_q     <= s1_len_d;
         s1_if_q      <= s1_if_d;
         s2_valid_q   <= s2_valid_d;
         s2_hit_q     <= s2_hit_d;
         s2_key_q     <= s2_key_d;
         s2_len_q     <= s2_len_d;
         s2_if_q      <= s2_if_d;
         s2_idx_q     <= s2_idx_d;
         res_valid_q  <= res_valid_d;
         res_hit_q    <= res_hit_d;
         res_prefix_q <= res_prefix_d;
         res_len_q    <= res_len_d;
         res_if_q     <= res_if_d;
         res_idx_q    <= res_idx_d;
      end
   end

   assign res_valid  = res_valid_q;
   assign res_hit    = res_hit_q;
   assign res_prefix = res_prefix_q;
   assign res_len    = res_len_q;
   assign res_if     = res_if_q;
   assign res_idx    = res_idx_q;
   assign wr_err     = wr_err_q;

endmodule
`default_nettype wire
